inport_arbiter: RTL

Ingress scheduler sharing the single 1024-bit InPort parser between `NUM_PORTS` ingress packet sources. It accepts at most one packet per cycle from the requesters using round-robin arbitration with a per-port enable mask. The granted packet is registered and driven as `io_en`/`io_data` into InPort, together with the source port id. The output register honours a pipeline stall, and per-port accepted-packet counters support debug.

---
 rtl/inport_pkg.sv | 24 ++
 rtl/inport_arbiter_if.sv | 32 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/inport_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/inport_pkg.sv
// Shared definitions for the InPort ingress path: PHV geometry, port-id sizing
// and the registered output beat layout.
package inport_pkg;

    localparam int PHV_BYTES = 128;
    localparam int DATA_W    = PHV_BYTES * 8;
    localparam int DEF_PORTS = 4;

    // Port-id width for n requesters; never narrower than one bit.
    function automatic int port_id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_W = port_id_w(DEF_PORTS);

    typedef logic [DEF_ID_W-1:0] port_id_t;

    typedef struct packed {
        logic              valid;
        port_id_t          port_id;
        logic [DATA_W-1:0] data;
    } out_beat_t;

endpackage

// File: rtl/inport_arbiter_if.sv
// Handshake, output and debug-counter bundle between the ingress sources and
// the InPort scheduler.
interface inport_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 1024,
    parameter int CNT_W     = 32
);
    localparam int ID_W = inport_pkg::port_id_w(NUM_PORTS);

    logic [NUM_PORTS-1:0]        io_in_valid;
    logic [NUM_PORTS*DATA_W-1:0] io_in_data;
    logic [NUM_PORTS-1:0]        io_in_ready;
    logic [NUM_PORTS-1:0]        io_port_en;
    logic                        io_stall;
    logic                        io_en;
    logic [DATA_W-1:0]           io_data;
    logic [ID_W-1:0]             io_port_id;
    logic [ID_W-1:0]             io_cnt_sel;
    logic [CNT_W-1:0]            io_cnt_value;
    logic                        io_cnt_clr;

    modport master (
        output io_in_valid, io_in_data, io_port_en, io_stall, io_cnt_sel, io_cnt_clr,
        input  io_in_ready, io_en, io_data, io_port_id, io_cnt_value
    );

    modport slave (
        input  io_in_valid, io_in_data, io_port_en, io_stall, io_cnt_sel, io_cnt_clr,
        output io_in_ready, io_en, io_data, io_port_id, io_cnt_value
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 upward with wrap and
// returns the first eligible requester as one-hot plus binary id.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = inport_pkg::port_id_w(N)
) (
    input  logic [N-1:0]    i_elig,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_grant_id
);

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        int w_idx;
        o_grant    = '0;
        o_grant_id = '0;
        w_idx      = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (i_elig[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_grant_id     = ID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/inport_arbiter.sv
// Ingress scheduler feeding the shared InPort parser: round-robin grant with
// per-port enable, stall-aware output register and per-port packet counters.
module inport_arbiter
    import inport_pkg::port_id_w;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = inport_pkg::DATA_W,
    parameter int CNT_W     = 32
) (
    input logic             clock,
    input logic             reset,
    inport_arbiter_if.slave bus
);

    localparam int ID_W = port_id_w(NUM_PORTS);

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   port_id;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t                r_out;
    logic [ID_W-1:0]      r_ptr;
    logic [CNT_W-1:0]     r_cnt [NUM_PORTS];

    logic [NUM_PORTS-1:0] w_elig;
    logic [NUM_PORTS-1:0] w_grant;
    logic [ID_W-1:0]      w_grant_id;
    logic                 w_load;
    logic                 w_xfer;
    logic [DATA_W-1:0]    w_sel_data;
    logic [CNT_W-1:0]     w_cnt_rd;

    assign w_elig = bus.io_in_valid & bus.io_port_en;
    assign w_load = !r_out.valid || !bus.io_stall;

    rr_arbiter #(.N(NUM_PORTS), .ID_W(ID_W)) u_rr (
        .i_elig     (w_elig),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    assign bus.io_in_ready = (w_load && !reset) ? w_grant : '0;
    assign w_xfer          = |(bus.io_in_valid & bus.io_in_ready);
    assign w_sel_data      = bus.io_in_data[int'(w_grant_id)*DATA_W +: DATA_W];

    // Pointer only moves on a real transfer so disabled/idle ports keep their turn.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out <= '0;
            r_ptr <= ID_W'(NUM_PORTS-1);
        end else if (w_load) begin
            r_out.valid <= w_xfer;
            if (w_xfer) begin
                r_out.port_id <= w_grant_id;
                r_out.data    <= w_sel_data;
                r_ptr         <= w_grant_id;
            end
        end
    end

    // Clear and count in the same cycle leaves the granted port at one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_xfer && (w_grant_id == ID_W'(i)))
                    r_cnt[i] <= bus.io_cnt_clr ? CNT_W'(1) : r_cnt[i] + CNT_W'(1);
                else if (bus.io_cnt_clr)
                    r_cnt[i] <= '0;
            end
        end
    end

    always_comb begin
        w_cnt_rd = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (bus.io_cnt_sel == ID_W'(i)) w_cnt_rd = r_cnt[i];
    end

    assign bus.io_en        = r_out.valid;
    assign bus.io_data      = r_out.data;
    assign bus.io_port_id   = r_out.port_id;
    assign bus.io_cnt_value = w_cnt_rd;

endmodule
